pick_place_sequencer: RTL and testbench

PICK_PLACE_SEQUENCER -- requirements
Module: pick_place_sequencer

---
 rtl/pick_place_pkg.sv | 57 +++++
 rtl/cmd_fifo.sv | 54 +++++
 rtl/pick_place_sequencer.sv | 131 +++++++++++++
 tb/tb_pick_place_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pick_place_pkg.sv
// Shared state encoding, opcode constants and command-field layout for the
// pick-and-place arm sequencer.
package pick_place_pkg;

   localparam int unsigned CMD_W   = 4;
   localparam int unsigned OP_MSB  = 3;
   localparam int unsigned OP_LSB  = 2;
   localparam int unsigned DST_BIT = 1;
   localparam int unsigned SRC_BIT = 0;

   localparam logic [1:0] OP_NOP_A = 2'b00;
   localparam logic [1:0] OP_MOVE  = 2'b01;
   localparam logic [1:0] OP_HOME  = 2'b10;
   localparam logic [1:0] OP_NOP_B = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_ROT_SRC,
      S_PUSH_SRC,
      S_GRIP,
      S_LIFT_SRC,
      S_ROT_DST,
      S_PUSH_DST,
      S_RELEASE,
      S_LIFT_DST,
      S_HOMING
   } state_t;

   typedef struct packed {
      logic side;
      logic push;
      logic pinch;
      logic busy;
   } servo_t;

   // Servo levels held while in state s; side is kept unless the state rotates.
   function automatic servo_t state_servo(input state_t s, input logic src,
                                          input logic dst, input logic side);
      servo_t o;
      o = '{side: side, push: 1'b0, pinch: 1'b0, busy: 1'b1};
      case (s)
         S_ROT_SRC:  o.side = src;
         S_PUSH_SRC: o.push = 1'b1;
         S_GRIP:     begin o.push = 1'b1; o.pinch = 1'b1; end
         S_LIFT_SRC: o.pinch = 1'b1;
         S_ROT_DST:  begin o.side = dst; o.pinch = 1'b1; end
         S_PUSH_DST: begin o.push = 1'b1; o.pinch = 1'b1; end
         S_RELEASE:  o.push = 1'b1;
         S_LIFT_DST: o.busy = 1'b1;
         S_HOMING:   o.side = 1'b0;
         default:    o.busy = 1'b0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue; dout always shows the head entry, flush empties it.
module cmd_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pick_place_sequencer.sv
// Pick-and-place arm sequencer: queues commands and steps the servos through
// timed MOVE / HOME motion programs.
module pick_place_sequencer
   import pick_place_pkg::*;
#(
   parameter int unsigned STEP_TICKS = 25000000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CMD_W-1:0] cmd,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             clear,
   input  logic             hold,
   output logic             sw_0,
   output logic             sw_180,
   output logic             sw_push,
   output logic             sw_pinch,
   output logic             busy,
   output logic             isdone
);

   localparam int unsigned TIMER_W = $clog2(STEP_TICKS + 1);
   localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(STEP_TICKS - 1);

   state_t             state;
   state_t             state_nxt_c;
   servo_t             servo_nxt_c;
   logic [TIMER_W-1:0] timer;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CMD_W-1:0]   fifo_dout;
   logic               pop_c;
   logic               accept_c;
   logic               dst_side;
   logic               done_flag;

   assign cmd_ready = ~fifo_full;
   assign accept_c  = cmd_valid && !fifo_full && !clear;
   assign isdone    = done_flag && (state == S_IDLE) && fifo_empty;

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clear),
      .push  (accept_c),
      .pop   (pop_c),
      .din   (cmd),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

   // Next-state decode; hold freezes every transition including the pop.
   always_comb begin
      state_nxt_c = state;
      pop_c       = 1'b0;
      if (!hold) begin
         case (state)
            S_IDLE: if (!fifo_empty) state_nxt_c = S_FETCH;
            S_FETCH: begin
               if (fifo_empty) begin
                  state_nxt_c = S_IDLE;
               end else begin
                  pop_c = 1'b1;
                  case (fifo_dout[OP_MSB:OP_LSB])
                     OP_MOVE: state_nxt_c = S_ROT_SRC;
                     OP_HOME: state_nxt_c = S_HOMING;
                     default: state_nxt_c = S_FETCH;
                  endcase
               end
            end
            default: begin
               if (timer == '0) begin
                  case (state)
                     S_ROT_SRC:  state_nxt_c = S_PUSH_SRC;
                     S_PUSH_SRC: state_nxt_c = S_GRIP;
                     S_GRIP:     state_nxt_c = S_LIFT_SRC;
                     S_LIFT_SRC: state_nxt_c = S_ROT_DST;
                     S_ROT_DST:  state_nxt_c = S_PUSH_DST;
                     S_PUSH_DST: state_nxt_c = S_RELEASE;
                     S_RELEASE:  state_nxt_c = S_LIFT_DST;
                     default:    state_nxt_c = S_FETCH;
                  endcase
               end
            end
         endcase
      end
   end

   // Source side is only needed on the FETCH edge, while the head is still visible.
   assign servo_nxt_c = state_servo(state_nxt_c, fifo_dout[SRC_BIT], dst_side, sw_180);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state     <= S_IDLE;
         timer     <= '0;
         sw_0      <= 1'b1;
         sw_180    <= 1'b0;
         sw_push   <= 1'b0;
         sw_pinch  <= 1'b0;
         busy      <= 1'b0;
         dst_side  <= 1'b0;
         done_flag <= 1'b0;
      end else begin
         state <= state_nxt_c;
         if (state_nxt_c != state) begin
            timer    <= TIMER_RELOAD;
            sw_0     <= ~servo_nxt_c.side;
            sw_180   <= servo_nxt_c.side;
            sw_push  <= servo_nxt_c.push;
            sw_pinch <= servo_nxt_c.pinch;
            busy     <= servo_nxt_c.busy;
         end else if (!hold && timer != '0) begin
            timer <= timer - TIMER_W'(1);
         end
         if (pop_c) dst_side <= fifo_dout[DST_BIT];
         if (accept_c) begin
            done_flag <= 1'b0;
         end else if (state_nxt_c == S_FETCH &&
                      (state == S_LIFT_DST || state == S_HOMING)) begin
            done_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pick_place_sequencer.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-and-program reference model of the sequencer.
module tb_pick_place_sequencer;

   localparam int unsigned STEP  = 4;
   localparam int unsigned DEPTH = 8;
   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_RUN   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] cmd = 4'h0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       clear = 1'b0;
   logic       hold = 1'b0;
   logic       sw_0, sw_180, sw_push, sw_pinch, busy, isdone;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   pick_place_sequencer #(.STEP_TICKS(STEP), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .clear(clear), .hold(hold), .sw_0(sw_0), .sw_180(sw_180), .sw_push(sw_push),
      .sw_pinch(sw_pinch), .busy(busy), .isdone(isdone));

   // Reference model: a command queue and a list of pending motion steps.
   typedef struct { int rot; logic push; logic pinch; } step_t;
   logic [3:0] q[$];
   step_t      prog[$];
   int         mode = M_IDLE;
   int         rem = 0;
   logic       m_side = 1'b0, m_push = 1'b0, m_pinch = 1'b0, m_busy = 1'b0, m_done = 1'b0;

   function automatic step_t mk(input int rot, input logic push, input logic pinch);
      step_t s;
      s.rot = rot; s.push = push; s.pinch = pinch;
      return s;
   endfunction

   task automatic start_step();
      step_t s;
      s = prog[0];
      if (s.rot >= 0) m_side = (s.rot == 1);
      m_push  = s.push;
      m_pinch = s.pinch;
      m_busy  = 1'b1;
      rem     = int'(STEP);
   endtask

   task automatic model_step(input logic v, input logic [3:0] c, input logic h,
                             input logic cl, input logic r);
      logic       acc;
      logic [3:0] head;
      if (r || cl) begin
         q.delete(); prog.delete();
         mode = M_IDLE; m_side = 1'b0; m_push = 1'b0; m_pinch = 1'b0;
         m_busy = 1'b0; m_done = 1'b0;
         return;
      end
      acc = v && (q.size() < int'(DEPTH));
      if (!h) begin
         if (mode == M_IDLE) begin
            if (q.size() != 0) mode = M_FETCH;
         end else if (mode == M_FETCH) begin
            if (q.size() == 0) mode = M_IDLE;
            else begin
               head = q.pop_front();
               if (head[3:2] == 2'b01) begin
                  prog.push_back(mk(head[0] ? 1 : 0, 1'b0, 1'b0));
                  prog.push_back(mk(-1, 1'b1, 1'b0));
                  prog.push_back(mk(-1, 1'b1, 1'b1));
                  prog.push_back(mk(-1, 1'b0, 1'b1));
                  prog.push_back(mk(head[1] ? 1 : 0, 1'b0, 1'b1));
                  prog.push_back(mk(-1, 1'b1, 1'b1));
                  prog.push_back(mk(-1, 1'b1, 1'b0));
                  prog.push_back(mk(-1, 1'b0, 1'b0));
                  mode = M_RUN; start_step();
               end else if (head[3:2] == 2'b10) begin
                  prog.push_back(mk(0, 1'b0, 1'b0));
                  mode = M_RUN; start_step();
               end
            end
         end else begin
            rem--;
            if (rem == 0) begin
               void'(prog.pop_front());
               if (prog.size() == 0) begin
                  mode = M_FETCH; m_busy = 1'b0; m_push = 1'b0; m_pinch = 1'b0;
                  m_done = 1'b1;
               end else start_step();
            end
         end
      end
      if (acc) begin
         q.push_back(c);
         m_done = 1'b0;
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      chk_bit("sw_0", sw_0, ~m_side);
      chk_bit("sw_180", sw_180, m_side);
      chk_bit("sw_push", sw_push, m_push);
      chk_bit("sw_pinch", sw_pinch, m_pinch);
      chk_bit("busy", busy, m_busy);
      chk_bit("cmd_ready", cmd_ready, q.size() < int'(DEPTH));
      chk_bit("isdone", isdone, m_done && mode == M_IDLE && q.size() == 0);
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge.
   task automatic cycle(input logic v, input logic [3:0] c, input logic h,
                        input logic cl, input logic r);
      cmd_valid = v; cmd = c; hold = h; clear = cl; rst = r;
      model_step(v, c, h, cl, r);
      @(posedge clk);
      #1;
      check_all();
   endtask

   int         busy_cnt, side_cnt, last_busy, first_done, acc_cnt, grip_cnt, grip_chg;
   int         nop_chg, hold_left;
   bit         found, seen_busy;
   logic       ready_before, rv, rh, rc, rr;
   logic [3:0] snap, rcmd;

   task automatic grip_tally();
      if (sw_push && sw_pinch) begin
         grip_cnt++;
         if ({sw_0, sw_180, sw_push, sw_pinch} != snap) grip_chg++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk_bit("rst_sw_0", sw_0, 1'b1);
      chk_bit("rst_cmd_ready", cmd_ready, 1'b1);
      chk_bit("rst_isdone", isdone, 1'b0);

      // MOVE src=0 dst=1
      cycle(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
      busy_cnt = 0; side_cnt = 0; last_busy = -100; first_done = -1;
      for (int i = 0; i < 45; i++) begin
         cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
         if (busy) begin
            busy_cnt++;
            if (sw_0) side_cnt++;
            last_busy = i;
         end
         if (isdone && first_done < 0) first_done = i;
      end
      chk_int("move_busy_cycles", busy_cnt, 32);
      chk_int("move_src_side_cycles", side_cnt, 16);
      chk_int("move_isdone_delay", first_done - last_busy, 2);
      chk_bit("move_end_sw_180", sw_180, 1'b1);

      // NOP then HOME, starting from side 180
      cycle(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
      busy_cnt = 0; nop_chg = 0; seen_busy = 1'b0;
      for (int i = 0; i < 15; i++) begin
         cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
         if (busy) begin busy_cnt++; seen_busy = 1'b1; end
         else if (!seen_busy && !sw_180) nop_chg++;
      end
      chk_int("nop_no_motion", nop_chg, 0);
      chk_int("home_busy_cycles", busy_cnt, 4);
      chk_bit("home_sw_0", sw_0, 1'b1);
      chk_bit("home_isdone", isdone, 1'b1);

      // hold for 10 cycles starting at GRIP cycle 2
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
         found = sw_push && sw_pinch;
      end
      chk_bit("grip_reached", found, 1'b1);
      grip_cnt = 1; grip_chg = 0; snap = {sw_0, sw_180, sw_push, sw_pinch};
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      grip_tally();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
         grip_tally();
      end
      for (int i = 0; i < 10 && sw_push && sw_pinch; i++) begin
         cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
         grip_tally();
      end
      chk_int("grip_length_with_hold", grip_cnt, 14);
      chk_int("grip_outputs_changed", grip_chg, 0);

      // clear during ROT_DST with 3 queued and a command presented
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
         found = busy && sw_180;
      end
      chk_bit("rot_dst_reached", found, 1'b1);
      cycle(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0);
      chk_bit("clear_busy", busy, 1'b0);
      chk_bit("clear_sw_0", sw_0, 1'b1);
      chk_bit("clear_push", sw_push, 1'b0);
      chk_bit("clear_pinch", sw_pinch, 1'b0);
      chk_bit("clear_isdone", isdone, 1'b0);
      busy_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
         if (busy) busy_cnt++;
      end
      chk_int("clear_queue_empty", busy_cnt, 0);

      // rst in the middle of PUSH_DST
      cycle(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
         found = sw_180 && sw_push && sw_pinch;
      end
      chk_bit("push_dst_reached", found, 1'b1);
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1);
      chk_bit("midrst_sw_0", sw_0, 1'b1);
      chk_bit("midrst_sw_180", sw_180, 1'b0);
      chk_bit("midrst_push", sw_push, 1'b0);
      chk_bit("midrst_pinch", sw_pinch, 1'b0);
      chk_bit("midrst_busy", busy, 1'b0);
      chk_bit("midrst_isdone", isdone, 1'b0);
      chk_bit("midrst_cmd_ready", cmd_ready, 1'b1);

      // 9 back-to-back HOMEs while held idle
      acc_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         ready_before = cmd_ready;
         cycle(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
         if (ready_before) acc_cnt++;
      end
      chk_int("fill_accepted", acc_cnt, 8);
      chk_bit("fill_ready_low", cmd_ready, 1'b0);
      found = 1'b0; busy_cnt = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         ready_before = cmd_ready;
         cycle(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
         if (busy) busy_cnt++;
         found = ready_before;
      end
      chk_bit("ninth_accepted", found, 1'b1);
      for (int i = 0; i < 80; i++) begin
         cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
         if (busy) busy_cnt++;
      end
      chk_int("nine_homes_busy", busy_cnt, 36);
      chk_bit("nine_homes_isdone", isdone, 1'b1);

      // Randomized traffic
      hold_left = 0;
      for (int i = 0; i < 3000; i++) begin
         rv   = ($urandom_range(0, 3) == 0);
         rcmd = 4'($urandom);
         if (hold_left == 0 && $urandom_range(0, 40) == 0) hold_left = $urandom_range(1, 12);
         rh = (hold_left > 0);
         if (hold_left > 0) hold_left--;
         rc = ($urandom_range(0, 300) == 0);
         rr = ($urandom_range(0, 700) == 0);
         cycle(rv, rcmd, rh, rc, rr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
